// File: rtl/mac_accum.sv
// mac_accum
// Multiply-accumulate stage ahead of the output shifter. It accepts a stream of
// unsigned DATA_WIDTH-bit sample/coefficient pairs and sums their products over
// (i_num_taps + 1) taps. The sum is presented on a valid/ready interface.
//
// Ports
//   i_clk        clock, all state updates on the rising edge
//   i_rst        synchronous active-high reset
//   i_start      begin a new accumulation (IDLE, or HOLD during the handshake)
//   i_num_taps   tap count minus one, latched on an accepted start
//   i_in_valid   sample/coeff pair valid
//   o_in_ready   block can accept a pair (high only in ACCUM)
//   i_sample     unsigned sample
//   i_coeff      unsigned coefficient
//   o_out_valid  o_acc_out holds a completed result (high only in HOLD)
//   i_out_ready  downstream accepts the result
//   o_acc_out    accumulated sum, driven directly from the accumulator
//   o_busy       high in ACCUM or HOLD
//
// ACC_WIDTH must be strictly greater than 2*DATA_WIDTH (the zero-extension
// below uses a non-zero replication); with the defaults, 16 taps of 255*255
// cannot overflow 20 bits. Wider tap counts simply wrap modulo 2^ACC_WIDTH.
module mac_accum #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int TAPS_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [TAPS_WIDTH-1:0] i_num_taps,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [DATA_WIDTH-1:0] i_sample,
  input  logic [DATA_WIDTH-1:0] i_coeff,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [ACC_WIDTH-1:0]  o_acc_out,
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ACC_WIDTH-1:0]    r_acc;
  logic [ACC_WIDTH-1:0]    w_acc_nxt;
  logic [TAPS_WIDTH-1:0]   r_tap_cnt;
  logic [TAPS_WIDTH-1:0]   w_tap_cnt_nxt;
  logic [TAPS_WIDTH-1:0]   r_tap_cnt_max;
  logic [TAPS_WIDTH-1:0]   w_tap_cnt_max_nxt;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic                    r_busy;

  logic [2*DATA_WIDTH-1:0] w_prod;
  logic [ACC_WIDTH-1:0]    w_prod_ext;
  logic                    w_in_fire;
  logic                    w_out_fire;

  assign w_prod     = {{DATA_WIDTH{1'b0}}, i_sample} * {{DATA_WIDTH{1'b0}}, i_coeff};
  assign w_prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){1'b0}}, w_prod};
  // Handshakes use the registered flags, so neither ready nor valid ever
  // depends combinationally on the partner's signal.
  assign w_in_fire  = i_in_valid && r_in_ready;
  assign w_out_fire = r_out_valid && i_out_ready;

  // Next-state and datapath update for the IDLE/ACCUM/HOLD controller.
  always_comb begin
    w_state_nxt       = r_state;
    w_acc_nxt         = r_acc;
    w_tap_cnt_nxt     = r_tap_cnt;
    w_tap_cnt_max_nxt = r_tap_cnt_max;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_tap_cnt_max_nxt = i_num_taps;
          w_tap_cnt_nxt     = {TAPS_WIDTH{1'b0}};
          w_acc_nxt         = {ACC_WIDTH{1'b0}};
          w_state_nxt       = S_ACCUM;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACCUM: begin
        if (w_in_fire) begin
          w_acc_nxt     = r_acc + w_prod_ext;
          w_tap_cnt_nxt = r_tap_cnt + {{(TAPS_WIDTH-1){1'b0}}, 1'b1};
          // The pair being accepted is the last tap of this run.
          if (r_tap_cnt == r_tap_cnt_max) begin
            w_state_nxt = S_HOLD;
          end else begin
            w_state_nxt = S_ACCUM;
          end
        end else begin
          w_state_nxt = S_ACCUM;
        end
      end
      S_HOLD: begin
        if (w_out_fire) begin
          if (i_start) begin
            // Back-to-back: restart directly without passing through IDLE.
            w_tap_cnt_max_nxt = i_num_taps;
            w_tap_cnt_nxt     = {TAPS_WIDTH{1'b0}};
            w_acc_nxt         = {ACC_WIDTH{1'b0}};
            w_state_nxt       = S_ACCUM;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      default: begin
        w_state_nxt       = S_IDLE;
        w_acc_nxt         = {ACC_WIDTH{1'b0}};
        w_tap_cnt_nxt     = {TAPS_WIDTH{1'b0}};
        w_tap_cnt_max_nxt = {TAPS_WIDTH{1'b0}};
      end
    endcase
  end

  // State, datapath and output-flag registers; flags are decoded from the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_acc         <= {ACC_WIDTH{1'b0}};
      r_tap_cnt     <= {TAPS_WIDTH{1'b0}};
      r_tap_cnt_max <= {TAPS_WIDTH{1'b0}};
      r_in_ready    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_acc         <= w_acc_nxt;
      r_tap_cnt     <= w_tap_cnt_nxt;
      r_tap_cnt_max <= w_tap_cnt_max_nxt;
      r_in_ready    <= (w_state_nxt == S_ACCUM);
      r_out_valid   <= (w_state_nxt == S_HOLD);
      r_busy        <= (w_state_nxt == S_ACCUM) || (w_state_nxt == S_HOLD);
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
  assign o_acc_out   = r_acc;

endmodule

// File: doc/mac_accum.md
# mac_accum

Multiply-accumulate stage feeding the output shifter: it accepts a stream of unsigned 8-bit sample/coefficient pairs and sums their products over a programmable number of taps. It presents the 20-bit sum on a valid/ready interface, and the downstream shifter selects the 8-bit window from that sum. The block is sized so that the maximum tap count can never overflow the accumulator.

## Interface
- DATA_WIDTH, 8, width of sample and coeff (unsigned)
- ACC_WIDTH, 20, accumulator/result width; must be ≥ 2*DATA_WIDTH + TAPS_WIDTH
- TAPS_WIDTH, 4, width of num_taps; max taps = 2^TAPS_WIDTH
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a new accumulation; sampled only in IDLE, or in HOLD during the output handshake
- num_taps  input  TAPS_WIDTH  tap count minus one (0 → 1 tap, 15 → 16 taps); latched on an accepted start
- in_valid  input  1  sample/coeff pair valid
- in_ready  output  1  block can accept a pair
- sample  input  DATA_WIDTH  unsigned sample
- coeff  input  DATA_WIDTH  unsigned coefficient
- out_valid  output  1  acc_out holds a completed result
- out_ready  input  1  downstream accepts the result
- acc_out  output  ACC_WIDTH  accumulated sum (to shifter `in`)
- busy  output  1  high in ACCUM or HOLD

## Operation
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - start=1 → latch num_taps into tap_cnt_max, clear tap_cnt and acc to 0, go to ACCUM.
  - start=0 → stay in IDLE.
- ACCUM:
  - in_ready=1.
  - On in_valid&&in_ready: acc <= acc + sample*coeff (full 16-bit product, zero-extended), tap_cnt <= tap_cnt+1.
  - When the accepted pair is tap number tap_cnt_max (i.e. tap_cnt==tap_cnt_max at acceptance) → go to HOLD.
  - in_valid=0 cycles: no change to acc or tap_cnt (bubbles allowed, no timeout).
  - start is ignored.
- HOLD:
  - out_valid=1, in_ready=0; acc_out is stable while out_valid && !out_ready.
  - On out_valid&&out_ready with start=0 → IDLE.
  - On out_valid&&out_ready with start=1 → latch num_taps, clear acc/tap_cnt, go directly to ACCUM (back-to-back).
  - start without out_ready is ignored.
- Width rules:
  - Arithmetic is unsigned, no saturation. With the defaults, 16*255*255 = 1,040,400 < 2^20, so overflow is impossible.
  - With other parameters, the sum wraps modulo 2^ACC_WIDTH.
- acc_out is driven directly from acc. After handshake it holds the last result in IDLE until the next accepted start clears it.
- Reset (any state, including mid-accumulation):
  - State returns to IDLE; acc=0, tap_cnt=0, tap_cnt_max=0.
  - Outputs after reset: out_valid=0, in_ready=0, busy=0, acc_out=0.
  - Partial sums are discarded; no result is emitted.

## Timing
- Start accepted at cycle t → in_ready=1 and busy=1 from cycle t+1.
- Accumulation is single-cycle: each accepted pair is reflected in acc on the next edge.
- Last pair accepted at cycle c → out_valid=1 and acc_out=final sum at cycle c+1.
- Minimum latency from start to out_valid is N+1 cycles for N taps with in_valid held high.
- Output handshake at cycle h:
  - Without start: out_valid=0 and busy=0 at h+1.
  - With start: out_valid=0, in_ready=1, busy=1 at h+1, and acc_out=0 at h+1.
- in_ready is a registered function of state only; it never depends combinationally on in_valid.
- out_valid never depends combinationally on out_ready.

## Test plan
- Reset then idle:
  - All outputs 0 after rst.
  - in_valid pulses in IDLE leave acc_out=0 and in_ready=0.
- Single tap:
  - Stimulus: num_taps=0, start, then pair (3,5) with out_ready=1.
  - Response: out_valid one cycle after acceptance, acc_out=15, then IDLE.
- Max taps, max values:
  - Stimulus: num_taps=15, 16 pairs of (255,255) back-to-back.
  - Response: acc_out=0xFE010 (1,040,400) exactly 17 cycles after start+1; no wrap.
- Input bubbles and output stall:
  - Stimulus: num_taps=3, pairs (1,1),(2,2),(3,3),(4,4) with in_valid deasserted between them; out_ready=0 for 5 cycles.
  - Response: acc_out=30 held stable with out_valid=1 throughout the stall; extra in_valid during HOLD is not accepted.
- Back-to-back and start-while-busy:
  - Stimulus: start pulses during ACCUM; then start together with out_ready in HOLD.
  - Response: starts during ACCUM are ignored (result unchanged); the start with out_ready causes in_ready=1 and acc_out=0 on the next cycle.
- Reset mid-accumulation:
  - Stimulus: num_taps=7; assert rst after 4 pairs of (10,10).
  - Response: next cycle state is IDLE and acc_out=0. A fresh 1-tap run with (2,2) yields 4, with no residue from the aborted run.
